// File: rtl/lynx_tape.sv
// Cassette playback engine: turns FIFO bytes into a leader, a sync cycle, MSB-first
// square-wave data bits and a trailing gap on the ear line. Timing advances only while the motor runs.
module lynx_tape #(
  parameter int AW     = 4,
  parameter int HALF0  = 1000,
  parameter int HALF1  = 2000,
  parameter int HALFS  = 3000,
  parameter int LEAD_N = 768,
  parameter int GAP    = 40000,
  parameter int CW     = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ce,
  input  logic       motor,
  input  logic       start,
  input  logic       eof,
  input  logic       wr,
  input  logic [7:0] di,
  output logic       full,
  output logic       empty,
  output logic       ear,
  output logic       busy,
  output logic       underrun
);

  localparam int DEPTH = 1 << AW;
  localparam int LW    = (LEAD_N > 2) ? $clog2(LEAD_N) : 1;

  typedef enum logic [2:0] {IDLE, LEADER, SYNC, LOAD, DATA, TRAIL} stateT;

  stateT          state, stateNext;
  logic [CW-1:0]  tickCnt, tickNext, halfLen;
  logic [LW-1:0]  cycCnt, cycNext;
  logic [7:0]     shift, shiftNext;
  logic [2:0]     bitCnt, bitNext;
  logic           earNext, underrunNext, eofFlag;
  logic           tick, halfDone;

  logic [7:0]     mem [DEPTH];
  logic [AW-1:0]  wrPtr, rdPtr;
  logic [AW:0]    count, countNext;
  logic           push, pop;

  assign tick = ce && motor;
  assign push = wr && !full;

  always_comb begin
    halfLen = CW'(HALF0);
    case (state)
      SYNC:    halfLen = CW'(HALFS);
      DATA:    halfLen = shift[7] ? CW'(HALF1) : CW'(HALF0);
      TRAIL:   halfLen = CW'(GAP);
      default: halfLen = CW'(HALF0);
    endcase
  end

  assign halfDone = tick && (tickCnt == halfLen - CW'(1));

  always_comb begin
    case ({push, pop})
      2'b10:   countNext = count + (AW+1)'(1);
      2'b01:   countNext = count - (AW+1)'(1);
      default: countNext = count;
    endcase
  end

  // The ear level doubles as the half-cycle phase: high half while ear is 1.
  always_comb begin
    stateNext    = state;
    tickNext     = tickCnt;
    cycNext      = cycCnt;
    earNext      = ear;
    shiftNext    = shift;
    bitNext      = bitCnt;
    underrunNext = underrun;
    pop          = 1'b0;
    if (motor) begin
      if (tick && (state == LEADER || state == SYNC || state == DATA || state == TRAIL))
        tickNext = halfDone ? '0 : tickCnt + CW'(1);
      case (state)
        IDLE: begin
          earNext = 1'b0;
          if (start) begin
            stateNext    = LEADER;
            earNext      = 1'b1;
            tickNext     = '0;
            cycNext      = '0;
            underrunNext = 1'b0;
          end
        end
        LEADER: begin
          if (halfDone) begin
            earNext = !ear;
            if (!ear) begin
              if (cycCnt == LW'(LEAD_N - 1)) stateNext = SYNC;
              else cycNext = cycCnt + LW'(1);
            end
          end
        end
        SYNC: begin
          if (halfDone) begin
            if (ear) earNext = 1'b0;
            else stateNext = LOAD;
          end
        end
        // Zero-tick decision: the next bit's high half starts on the exit clock.
        LOAD: begin
          earNext  = 1'b0;
          tickNext = '0;
          if (!empty) begin
            pop       = 1'b1;
            shiftNext = mem[rdPtr];
            bitNext   = 3'd7;
            stateNext = DATA;
            earNext   = 1'b1;
          end else if (eofFlag) begin
            stateNext = TRAIL;
          end else begin
            underrunNext = 1'b1;
          end
        end
        DATA: begin
          if (halfDone) begin
            if (ear) begin
              earNext = 1'b0;
            end else if (bitCnt == 3'd0) begin
              stateNext = LOAD;
            end else begin
              shiftNext = {shift[6:0], 1'b0};
              bitNext   = bitCnt - 3'd1;
              earNext   = 1'b1;
            end
          end
        end
        TRAIL: begin
          earNext = 1'b0;
          if (halfDone) stateNext = IDLE;
        end
        default: stateNext = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      tickCnt  <= '0;
      cycCnt   <= '0;
      shift    <= '0;
      bitCnt   <= '0;
      ear      <= 1'b0;
      busy     <= 1'b0;
      underrun <= 1'b0;
      eofFlag  <= 1'b0;
    end else begin
      state    <= stateNext;
      tickCnt  <= tickNext;
      cycCnt   <= cycNext;
      shift    <= shiftNext;
      bitCnt   <= bitNext;
      ear      <= earNext;
      busy     <= (stateNext != IDLE);
      underrun <= underrunNext;
      if (state != IDLE && stateNext == IDLE) eofFlag <= 1'b0;
      else if (eof) eofFlag <= 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
      full  <= 1'b0;
      empty <= 1'b1;
    end else begin
      if (push) wrPtr <= wrPtr + AW'(1);
      if (pop) rdPtr <= rdPtr + AW'(1);
      count <= countNext;
      full  <= (countNext == (AW+1)'(DEPTH));
      empty <= (countNext == '0);
    end
  end

  // Storage needs no reset; clearing the pointers discards the contents.
  always_ff @(posedge clock) begin
    if (push) mem[wrPtr] <= di;
  end

endmodule
